// File: rtl/uart_cmd_decoder.sv
// Pulls SOF/ADDR/DHI/DLO/CHK frames from an upstream RX FIFO and presents
// checksum-verified commands on a valid/ready port, counting rejected frames.
module uart_cmd_decoder #(
  parameter logic [7:0]  SOF            = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        RxEmpty,
  input  logic [7:0]  ReadData,
  output logic        ReadUart,
  output logic        CmdValid,
  input  logic        CmdReady,
  output logic [7:0]  CmdAddr,
  output logic [15:0] CmdData,
  output logic        FrameError,
  output logic [7:0]  ErrorCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_addr;
  logic [7:0]  r_dhi;
  logic [7:0]  r_dlo;
  logic [7:0]  r_cmd_addr;
  logic [15:0] r_cmd_data;
  logic [7:0]  r_err_cnt;
  logic [19:0] r_tmo;
  logic        r_frame_err;
  logic        w_pop;
  logic        w_in_frame;
  logic        w_chk_ok;
  logic        w_tmo_hit;
  logic        w_err;

  assign w_pop      = ResetN & ~RxEmpty & (r_state != S_OUT);
  assign w_in_frame = (r_state == S_ADDR) | (r_state == S_DHI) |
                      (r_state == S_DLO)  | (r_state == S_CHK);
  assign w_chk_ok   = (ReadData == (SOF ^ r_addr ^ r_dhi ^ r_dlo));
  // Fires on the idle cycle that would bring the counter up to the limit.
  assign w_tmo_hit  = w_in_frame & ~w_pop & (r_tmo == TMO_LAST);
  assign w_err      = w_tmo_hit | ((r_state == S_CHK) & w_pop & ~w_chk_ok);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop && (ReadData == SOF)) w_next = S_ADDR;
        else                            w_next = S_IDLE;
      end
      S_ADDR: begin
        if (w_tmo_hit)  w_next = S_IDLE;
        else if (w_pop) w_next = S_DHI;
        else            w_next = S_ADDR;
      end
      S_DHI: begin
        if (w_tmo_hit)  w_next = S_IDLE;
        else if (w_pop) w_next = S_DLO;
        else            w_next = S_DHI;
      end
      S_DLO: begin
        if (w_tmo_hit)  w_next = S_IDLE;
        else if (w_pop) w_next = S_CHK;
        else            w_next = S_DLO;
      end
      S_CHK: begin
        if (w_tmo_hit)  w_next = S_IDLE;
        else if (w_pop) w_next = w_chk_ok ? S_OUT : S_IDLE;
        else            w_next = S_CHK;
      end
      S_OUT: begin
        if (CmdReady) w_next = S_IDLE;
        else          w_next = S_OUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ReadUart = w_pop;
    CmdValid = (r_state == S_OUT);
  end

  // Frame capture, command holding registers, timeout and error bookkeeping.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_addr      <= 8'h00;
      r_dhi       <= 8'h00;
      r_dlo       <= 8'h00;
      r_cmd_addr  <= 8'h00;
      r_cmd_data  <= 16'h0000;
      r_err_cnt   <= 8'h00;
      r_tmo       <= 20'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (!w_in_frame || w_pop) r_tmo <= 20'd0;
      else                      r_tmo <= r_tmo + 20'd1;
      if (w_pop) begin
        case (r_state)
          S_ADDR: r_addr <= ReadData;
          S_DHI:  r_dhi  <= ReadData;
          S_DLO:  r_dlo  <= ReadData;
          S_CHK: begin
            if (w_chk_ok) begin
              r_cmd_addr <= r_addr;
              r_cmd_data <= {r_dhi, r_dlo};
            end
          end
          default: r_addr <= r_addr;
        endcase
      end
    end
  end

  assign CmdAddr    = r_cmd_addr;
  assign CmdData    = r_cmd_data;
  assign FrameError = r_frame_err;
  assign ErrorCount = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a frame-level reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_uart_cmd_decoder;

  localparam int         TMO   = 100;
  localparam logic [7:0] SOF_V = 8'hA5;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        RxEmpty = 1'b1;
  logic [7:0]  ReadData = 8'h00;
  logic        ReadUart;
  logic        CmdValid;
  logic        CmdReady = 1'b1;
  logic [7:0]  CmdAddr;
  logic [15:0] CmdData;
  logic        FrameError;
  logic [7:0]  ErrorCount;

  uart_cmd_decoder #(.SOF(SOF_V), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .ResetN(ResetN), .RxEmpty(RxEmpty), .ReadData(ReadData),
    .ReadUart(ReadUart), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdAddr(CmdAddr), .CmdData(CmdData), .FrameError(FrameError),
    .ErrorCount(ErrorCount)
  );

  always #5 Clock = ~Clock;

  logic [7:0]  fifo[$];
  // reference model: collected frame bytes, pending command, error state
  logic [7:0]  m_frame[$];
  logic        m_pend = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_err = 1'b0;
  int          m_errcnt = 0;
  int          m_idle = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic        s_rst, s_pop, s_epop, s_valid, s_ready;
  logic [7:0]  s_head, s_addr;
  logic [15:0] s_data;
  logic [23:0] rx_cmds[$];
  int dut_err_pulses = 0;
  int pop10_cyc = 0;
  int err_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    logic e_pop;
    e_pop = ResetN && (fifo.size() != 0) && !m_pend;
    check("read_uart", 32'(ReadUart), 32'(e_pop));
    check("cmd_valid", 32'(CmdValid), 32'(ResetN && m_pend));
    if (!ResetN || m_pend) begin
      check("cmd_addr", 32'(CmdAddr), ResetN ? 32'(m_addr) : 32'd0);
      check("cmd_data", 32'(CmdData), ResetN ? 32'(m_data) : 32'd0);
    end
    check("frame_error", 32'(FrameError), ResetN ? 32'(m_err) : 32'd0);
    check("error_count", 32'(ErrorCount), ResetN ? 32'(m_errcnt) : 32'd0);
    s_rst   = ResetN;
    s_pop   = ReadUart;
    s_epop  = e_pop;
    s_head  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    s_valid = CmdValid;
    s_ready = CmdReady;
    s_addr  = CmdAddr;
    s_data  = CmdData;
    if (FrameError === 1'b1) begin
      dut_err_pulses++;
      err_cyc = cyc;
    end
  endtask

  task automatic model_step();
    logic       nerr;
    logic [7:0] x;
    nerr = 1'b0;
    if (!s_rst) begin
      m_pend = 1'b0; m_addr = 8'h00; m_data = 16'h0000;
      m_err = 1'b0; m_errcnt = 0; m_idle = 0;
      m_frame.delete();
    end else begin
      if (m_pend) begin
        if (s_ready) m_pend = 1'b0;
      end else if (s_epop) begin
        if (m_frame.size() == 0) begin
          if (s_head == SOF_V) begin
            m_frame.push_back(s_head);
            m_idle = 0;
          end
        end else begin
          m_frame.push_back(s_head);
          m_idle = 0;
          if (m_frame.size() == 5) begin
            x = m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3];
            if (x == m_frame[4]) begin
              m_pend = 1'b1;
              m_addr = m_frame[1];
              m_data = {m_frame[2], m_frame[3]};
            end else begin
              nerr = 1'b1;
            end
            m_frame.delete();
          end
        end
      end else if (m_frame.size() != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          nerr = 1'b1;
          m_frame.delete();
          m_idle = 0;
        end
      end
      m_err = nerr;
      if (nerr && m_errcnt < 255) m_errcnt++;
    end
    if (s_pop && fifo.size() != 0) begin
      if (s_head == 8'h10) pop10_cyc = cyc;
      void'(fifo.pop_front());
    end
    if (s_rst && s_valid && s_ready) rx_cmds.push_back({s_addr, s_data});
  endtask

  task automatic tick();
    RxEmpty  = (fifo.size() == 0);
    ReadData = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    compare_cycle();
    @(posedge Clock);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [7:0] e);
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
    fifo.push_back(d); fifo.push_back(e);
  endtask

  initial begin
    run(3);
    check("rst_err_cnt", 32'(ErrorCount), 32'd0);
    check("rst_valid", 32'(CmdValid), 32'd0);
    ResetN = 1'b1;
    run(2);

    // basic good frame: A5^10^12^34 = 93
    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h93);
    run(10);
    check("t31_count", 32'(rx_cmds.size()), 32'd1);
    check("t31_cmd", 32'(rx_cmds[0]), 32'h101234);
    check("t31_errs", 32'(dut_err_pulses), 32'd0);

    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h94);
    run(10);
    check("t32_errs", 32'(dut_err_pulses), 32'd1);
    check("t32_err_cnt", 32'(ErrorCount), 32'd1);
    check("t32_count", 32'(rx_cmds.size()), 32'd1);
    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h93);
    run(10);
    check("t32_recover", 32'(rx_cmds[1]), 32'h101234);

    fifo.push_back(8'h00); fifo.push_back(8'hFF); fifo.push_back(8'h3C);
    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h93);
    run(15);
    check("t33_count", 32'(rx_cmds.size()), 32'd3);
    check("t33_errs", 32'(dut_err_pulses), 32'd1);

    // backpressure: A5^20^AB^CD = E3
    CmdReady = 1'b0;
    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h93);
    push5(8'hA5, 8'h20, 8'hAB, 8'hCD, 8'hE3);
    run(20);
    check("t34_held_valid", 32'(CmdValid), 32'd1);
    check("t34_held_addr", 32'(CmdAddr), 32'h10);
    check("t34_fifo_kept", 32'(fifo.size()), 32'd5);
    CmdReady = 1'b1;
    run(15);
    check("t34_count", 32'(rx_cmds.size()), 32'd5);
    check("t34_first", 32'(rx_cmds[3]), 32'h101234);
    check("t34_second", 32'(rx_cmds[4]), 32'h20ABCD);

    fifo.push_back(8'hA5); fifo.push_back(8'h10);
    run(120);
    check("t35_tmo_delay", 32'(err_cyc - pop10_cyc), 32'd101);
    check("t35_errs", 32'(dut_err_pulses), 32'd2);
    check("t35_err_cnt", 32'(ErrorCount), 32'd2);

    fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h12);
    run(5);
    ResetN = 1'b0;
    run(2);
    check("rst_mid_valid", 32'(CmdValid), 32'd0);
    check("rst_mid_fe", 32'(FrameError), 32'd0);
    check("rst_mid_cnt", 32'(ErrorCount), 32'd0);
    check("rst_mid_addr", 32'({CmdAddr, CmdData}), 32'd0);
    ResetN = 1'b1;
    run(120);
    check("rst_no_err", 32'(dut_err_pulses), 32'd2);
    check("rst_no_cmd", 32'(rx_cmds.size()), 32'd5);
    // A5^7E^00^01 = DA
    push5(8'hA5, 8'h7E, 8'h00, 8'h01, 8'hDA);
    run(10);
    check("rst_restart", 32'(rx_cmds[5]), 32'h7E0001);

    for (int i = 0; i < 260; i++) push5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    run(1320);
    check("sat_err_cnt", 32'(ErrorCount), 32'd255);
    check("sat_pulses", 32'(dut_err_pulses), 32'd262);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
